// File: rtl/vram_wr_arb_if.sv
// VRAM port-B write arbiter bundle: requester side, frame sync and port B.
// master drives requests and vga_end; slave is the arbiter.
interface vram_wr_arb_if;
  logic        vga_end;
  logic        req0;
  logic        req1;
  logic [18:0] adr0;
  logic [18:0] adr1;
  logic [8:0]  dat0;
  logic [8:0]  dat1;
  logic        ack0;
  logic        ack1;
  logic [18:0] addrb;
  logic [8:0]  dinb;
  logic        web;
  logic        win_open;

  modport master (
    output vga_end, req0, req1,
    output adr0, adr1, dat0, dat1,
    input  ack0, ack1, addrb, dinb,
    input  web, win_open
  );

  modport slave (
    input  vga_end, req0, req1,
    input  adr0, adr1, dat0, dat1,
    output ack0, ack1, addrb, dinb,
    output web, win_open
  );
endinterface

// File: rtl/vram_wr_arb.sv
// Two-requester round-robin VRAM write arbiter.
// Writes are only granted inside the blanking window opened by vga_end.
module vram_wr_arb #(
  parameter logic [15:0] WIN_LEN   = 16'd35200,
  parameter logic [7:0]  MAX_BURST = 8'd64
) (
  input logic         clk_25mhz,
  input logic         RST_N,
  vram_wr_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t      state;
  logic        rr;
  logic [15:0] win_cnt;
  logic [6:0]  burst;
  logic        open;
  logic        issue0;
  logic        issue1;
  logic        cap;
  logic        pick0;

  assign open = (win_cnt != 16'd0);
  assign bus.win_open = open;

  // ack high blocks a second write so the requester can advance
  assign issue0 = (state == GNT0) && bus.req0
                && !bus.ack0 && open;
  assign issue1 = (state == GNT1) && bus.req1
                && !bus.ack1 && open;

  assign cap = (({1'b0, burst} + 8'd1) == MAX_BURST);
  assign pick0 = bus.req0 && (!bus.req1 || !rr);

  always_ff @(posedge clk_25mhz or negedge RST_N) begin
    if (!RST_N) begin
      win_cnt <= 16'd0;
    end else if (bus.vga_end) begin
      win_cnt <= WIN_LEN;
    end else if (open) begin
      win_cnt <= win_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk_25mhz or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      rr        <= 1'b0;
      burst     <= 7'd0;
      bus.web   <= 1'b0;
      bus.ack0  <= 1'b0;
      bus.ack1  <= 1'b0;
      bus.addrb <= 19'd0;
      bus.dinb  <= 9'd0;
    end else begin
      bus.web  <= issue0 | issue1;
      bus.ack0 <= issue0;
      bus.ack1 <= issue1;
      if (issue0) begin
        bus.addrb <= bus.adr0;
        bus.dinb  <= bus.dat0;
      end else if (issue1) begin
        bus.addrb <= bus.adr1;
        bus.dinb  <= bus.dat1;
      end
      if (issue0 | issue1) begin
        burst <= burst + 7'd1;
      end
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            open && pick0: begin
              state <= GNT0;
              burst <= 7'd0;
            end
            open && !pick0 && bus.req1: begin
              state <= GNT1;
              burst <= 7'd0;
            end
            default: state <= IDLE;
          endcase
        end
        GNT0: begin
          if (!bus.req0 || !open || (issue0 && cap)) begin
            state <= IDLE;
            rr    <= 1'b1;
          end
        end
        GNT1: begin
          if (!bus.req1 || !open || (issue1 && cap)) begin
            state <= IDLE;
            rr    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_wr_arb.sv
// Directed bench for vram_wr_arb with a short window and short bursts.
// Requester models either advance or drop their request on each ack.
module tb_vram_wr_arb;

  logic clk_25mhz;
  logic RST_N;
  int   n_cmp;
  int   n_err;
  int   nwr;
  bit   nxt0;
  bit   nxt1;

  vram_wr_arb_if bus ();

  vram_wr_arb #(
    .WIN_LEN  (16'd10),
    .MAX_BURST(8'd4)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .RST_N    (RST_N),
    .bus      (bus)
  );

  initial begin
    clk_25mhz = 1'b0;
    forever #20 clk_25mhz = ~clk_25mhz;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
    if (bus.web) nwr++;
    if (bus.ack0) begin
      if (nxt0) begin
        bus.adr0 = bus.adr0 + 19'd1;
        bus.dat0 = bus.dat0 + 9'd1;
      end else begin
        bus.req0 = 1'b0;
      end
    end
    if (bus.ack1) begin
      if (nxt1) begin
        bus.adr1 = bus.adr1 + 19'd1;
        bus.dat1 = bus.dat1 + 9'd1;
      end else begin
        bus.req1 = 1'b0;
      end
    end
  endtask

  task automatic pulse_vga();
    bus.vga_end = 1'b1;
    tick();
    bus.vga_end = 1'b0;
  endtask

  task automatic do_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    logic e0;
    logic e1;
    n_cmp = 0;
    n_err = 0;
    nwr   = 0;
    nxt0  = 1'b0;
    nxt1  = 1'b0;
    RST_N = 1'b0;
    bus.vga_end = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.adr0 = 19'd0;
    bus.adr1 = 19'd0;
    bus.dat0 = 9'd0;
    bus.dat1 = 9'd0;
    tick();
    tick();
    chk("rst_web", bus.web, 0);
    chk("rst_ack0", bus.ack0, 0);
    chk("rst_ack1", bus.ack1, 0);
    chk("rst_addrb", bus.addrb, 0);
    chk("rst_dinb", bus.dinb, 0);
    chk("rst_win", bus.win_open, 0);
    RST_N = 1'b1;

    // scenario 1: no write before the first window
    bus.req0 = 1'b1;
    bus.adr0 = 19'h00010;
    bus.dat0 = 9'h1FF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s1_nowin_web", bus.web, 0);
    end
    pulse_vga();
    chk("s1_win", bus.win_open, 1);
    tick();
    chk("s1_lat_web", bus.web, 0);
    tick();
    chk("s1_web", bus.web, 1);
    chk("s1_ack0", bus.ack0, 1);
    chk("s1_addrb", bus.addrb, 19'h00010);
    chk("s1_dinb", bus.dinb, 9'h1FF);
    tick();
    chk("s1_ack0_pulse", bus.ack0, 0);
    chk("s1_web_pulse", bus.web, 0);
    chk("s1_addrb_hold", bus.addrb, 19'h00010);

    // scenario 2: round-robin, bursts of 4
    do_reset();
    nxt0 = 1'b1;
    nxt1 = 1'b1;
    bus.adr0 = 19'h10000;
    bus.adr1 = 19'h20000;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    pulse_vga();
    for (int j = 2; j <= 34; j++) begin
      tick();
      e0 = (j % 2 == 1) &&
           ((j >= 3 && j <= 9) || (j >= 19 && j <= 25));
      e1 = (j % 2 == 1) &&
           ((j >= 11 && j <= 17) || (j >= 27 && j <= 33));
      chk($sformatf("s2_ack0_%0d", j), bus.ack0, e0);
      chk($sformatf("s2_ack1_%0d", j), bus.ack1, e1);
      if (j == 11) chk("s2_addrb1", bus.addrb, 19'h20000);
      if (j == 19) chk("s2_addrb0", bus.addrb, 19'h10004);
      bus.vga_end = (j % 8 == 0);
    end
    bus.vga_end = 1'b0;

    // scenario 3: window closes under a held request
    do_reset();
    nxt1 = 1'b1;
    bus.adr1 = 19'h30000;
    bus.req1 = 1'b1;
    pulse_vga();
    nwr = 0;
    for (int j = 2; j <= 14; j++) begin
      tick();
      if (j == 10) chk("s3_open10", bus.win_open, 1);
      if (j == 11) chk("s3_close11", bus.win_open, 0);
    end
    chk("s3_nwr", nwr, 5);
    chk("s3_held", bus.adr1, 19'h30005);
    pulse_vga();
    tick();
    tick();
    chk("s3_resume_web", bus.web, 1);
    chk("s3_resume_adr", bus.addrb, 19'h30005);

    // scenario 4: reload at counter value 3
    do_reset();
    pulse_vga();
    for (int j = 2; j <= 8; j++) tick();
    chk("s4_open8", bus.win_open, 1);
    bus.vga_end = 1'b1;
    tick();
    bus.vga_end = 1'b0;
    for (int j = 9; j <= 19; j++) begin
      if (j > 9) tick();
      chk($sformatf("s4_win_%0d", j), bus.win_open, j <= 18);
    end

    // scenario 5: reset during third write of the req1 burst
    do_reset();
    nxt0 = 1'b1;
    nxt1 = 1'b1;
    bus.adr0 = 19'h40000;
    bus.adr1 = 19'h50000;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    pulse_vga();
    for (int j = 2; j <= 15; j++) begin
      tick();
      bus.vga_end = (j % 8 == 0);
    end
    bus.vga_end = 1'b0;
    chk("s5_third_ack1", bus.ack1, 1);
    chk("s5_third_adr", bus.addrb, 19'h50002);
    #2;
    RST_N = 1'b0;
    #1;
    chk("s5_web", bus.web, 0);
    chk("s5_ack1", bus.ack1, 0);
    chk("s5_addrb", bus.addrb, 0);
    chk("s5_dinb", bus.dinb, 0);
    chk("s5_win", bus.win_open, 0);
    tick();
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s5_nowr", bus.web, 0);
    end
    pulse_vga();
    tick();
    tick();
    chk("s5_first_ack0", bus.ack0, 1);
    chk("s5_first_ack1", bus.ack1, 0);

    // scenario 6: req0 releases after one word
    do_reset();
    nxt0 = 1'b0;
    nxt1 = 1'b1;
    bus.adr1 = 19'h60000;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    pulse_vga();
    tick();
    chk("s6_ack0_e2", bus.ack0, 0);
    tick();
    chk("s6_ack0_e3", bus.ack0, 1);
    tick();
    chk("s6_ack1_e4", bus.ack1, 0);
    tick();
    chk("s6_ack1_e5", bus.ack1, 0);
    tick();
    chk("s6_ack1_e6", bus.ack1, 1);
    chk("s6_adr1", bus.addrb, 19'h60000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
